// File: rtl/i2s_sample_sequencer_if.sv
// i2s_sample_sequencer_if: stereo capture input and serialised valid/ready sample stream
interface i2s_sample_sequencer_if #(parameter int SAMPLE_W = 16);
    logic                sample_valid_in;
    logic [SAMPLE_W-1:0] left_sample_in;
    logic [SAMPLE_W-1:0] right_sample_in;
    logic                proc_ready_in;
    logic                proc_valid_out;
    logic [SAMPLE_W-1:0] proc_sample_out;
    logic                proc_channel_out;
    logic                proc_last_out;
    modport master (
        output sample_valid_in, left_sample_in, right_sample_in, proc_ready_in,
        input  proc_valid_out, proc_sample_out, proc_channel_out, proc_last_out
    );
    modport slave (
        input  sample_valid_in, left_sample_in, right_sample_in, proc_ready_in,
        output proc_valid_out, proc_sample_out, proc_channel_out, proc_last_out
    );
endinterface

// File: rtl/i2s_sample_sequencer.sv
// i2s_sample_sequencer: buffers stereo pairs and streams them left-then-right to one engine
module i2s_sample_sequencer #(
    parameter int DEPTH    = 4,
    parameter int SAMPLE_W = 16
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     enable_in,
    i2s_sample_sequencer_if.slave    bus,
    output logic [$clog2(DEPTH):0]   fifo_level_out,
    output logic [15:0]              overflow_count_out,
    output logic                     busy_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    typedef enum logic [1:0] {IDLE, SEND_L, SEND_R} state_t;
    state_t              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [15:0]         ovf_q, ovf_d;
    logic                valid_q, valid_d, chan_q, chan_d, last_q, last_d, busy_q, busy_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d, head_l;
    logic [SAMPLE_W-1:0] mem_l_q [DEPTH];
    logic [SAMPLE_W-1:0] mem_r_q [DEPTH];
    logic                pop, push_req, push;
    always_comb begin
        pop      = (state_q == SEND_R) && bus.proc_ready_in;
        push_req = bus.sample_valid_in && enable_in;
        push     = push_req && ((level_q != LW'(DEPTH)) || pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        ovf_d    = ovf_q + 16'(push_req && !push && (ovf_q != 16'hFFFF));
        // a pair arriving as the buffer drains becomes the head in the same cycle
        head_l   = (level_q == LW'(pop)) ? bus.left_sample_in : mem_l_q[rd_ptr_d];
        state_d  = state_q;
        valid_d  = valid_q;
        sample_d = sample_q;
        chan_d   = chan_q;
        last_d   = last_q;
        case (state_q)
            IDLE: if (level_q != '0) begin
                state_d  = SEND_L;
                valid_d  = 1'b1;
                sample_d = head_l;
                chan_d   = 1'b0;
                last_d   = 1'b0;
            end
            SEND_L: if (bus.proc_ready_in) begin
                state_d  = SEND_R;
                sample_d = mem_r_q[rd_ptr_q];
                chan_d   = 1'b1;
                last_d   = 1'b1;
            end
            SEND_R: if (bus.proc_ready_in) begin
                state_d  = (level_d != '0) ? SEND_L : IDLE;
                valid_d  = level_d != '0;
                sample_d = (level_d != '0) ? head_l : sample_q;
                chan_d   = 1'b0;
                last_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || (level_d != '0);
    end
    always_ff @(posedge clock_in) begin
        if (push) begin
            mem_l_q[wr_ptr_q] <= bus.left_sample_in;
            mem_r_q[wr_ptr_q] <= bus.right_sample_in;
        end
    end
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
            valid_q  <= 1'b0;
            sample_q <= '0;
            chan_q   <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            sample_q <= sample_d;
            chan_q   <= chan_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
        end
    end
    assign bus.proc_valid_out   = valid_q;
    assign bus.proc_sample_out  = sample_q;
    assign bus.proc_channel_out = chan_q;
    assign bus.proc_last_out    = last_q;
    assign fifo_level_out       = level_q;
    assign overflow_count_out   = ovf_q;
    assign busy_out             = busy_q;
endmodule

// File: tb/tb_i2s_sample_sequencer.sv
// tb_i2s_sample_sequencer: table vectors, directed corner cases and a queue-based reference model
module tb_i2s_sample_sequencer;
    localparam int DEPTH = 4;
    localparam int W     = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [LW-1:0] level;
    logic [15:0]   ovf;
    logic          busy;
    int            checks = 0;
    int            errors = 0;
    i2s_sample_sequencer_if #(.SAMPLE_W(W)) bus ();
    i2s_sample_sequencer #(.DEPTH(DEPTH), .SAMPLE_W(W)) dut (
        .clock_in(clk), .reset_in(rst), .enable_in(en), .bus(bus),
        .fifo_level_out(level), .overflow_count_out(ovf), .busy_out(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // reference: the buffer is a queue of {left,right}; a pair leaves when its right word is taken
    logic [31:0] mq[$];
    bit          mvalid = 1'b0;
    bit          half   = 1'b0;
    int          movf   = 0;
    always @(negedge clk) begin
        int sz;
        bit hs, pop, preq, push;
        if (rst) begin
            mq.delete();
            mvalid = 1'b0;
            half   = 1'b0;
            movf   = 0;
        end else begin
            chk("m_valid", 32'(bus.proc_valid_out), 32'(mvalid));
            chk("m_level", 32'(level), 32'(mq.size()));
            chk("m_ovf", 32'(ovf), 32'(movf));
            chk("m_busy", 32'(busy), 32'(mvalid || mq.size() != 0));
            if (mvalid) begin
                chk("m_word", 32'(bus.proc_sample_out), 32'(half ? mq[0][15:0] : mq[0][31:16]));
                chk("m_chan", 32'(bus.proc_channel_out), 32'(half));
                chk("m_last", 32'(bus.proc_last_out), 32'(half));
            end
            sz   = mq.size();
            hs   = mvalid && bus.proc_ready_in;
            pop  = hs && half;
            preq = bus.sample_valid_in && en;
            push = preq && (sz < DEPTH || pop);
            if (preq && !push && movf < 65535) movf++;
            if (!mvalid) mvalid = sz > 0;
            else if (pop) mvalid = (sz - 1 + int'(push)) > 0;
            if (hs) half = !half;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({bus.left_sample_in, bus.right_sample_in});
        end
    end
    typedef struct {
        bit          en, sv;
        logic [15:0] l, r;
        bit          rdy, ev;
        logic [15:0] es;
        bit          ec, el;
        int          elev, eovf;
    } vec_t;
    vec_t tv[12];
    initial begin
        bus.sample_valid_in = 1'b0;
        bus.left_sample_in  = '0;
        bus.right_sample_in = '0;
        bus.proc_ready_in   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.proc_valid_out), 0);
        chk("rst_sample", 32'(bus.proc_sample_out), 0);
        chk("rst_chan", 32'(bus.proc_channel_out), 0);
        chk("rst_last", 32'(bus.proc_last_out), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tv[0]  = '{1, 1, 16'h1234, 16'hFEDC, 1, 0, 16'h0000, 0, 0, 1, 0};
        tv[1]  = '{1, 0, 16'h0000, 16'h0000, 1, 1, 16'h1234, 0, 0, 1, 0};
        tv[2]  = '{1, 0, 16'h0000, 16'h0000, 1, 1, 16'hFEDC, 1, 1, 1, 0};
        tv[3]  = '{1, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 0};
        tv[4]  = '{1, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 0};
        tv[5]  = '{0, 1, 16'hAAAA, 16'h5555, 1, 0, 16'h0000, 0, 0, 0, 0};
        tv[6]  = '{1, 1, 16'h0001, 16'h8000, 1, 0, 16'h0000, 0, 0, 1, 0};
        tv[7]  = '{1, 1, 16'h7FFF, 16'hFFFF, 1, 1, 16'h0001, 0, 0, 2, 0};
        tv[8]  = '{1, 0, 16'h0000, 16'h0000, 1, 1, 16'h8000, 1, 1, 2, 0};
        tv[9]  = '{1, 0, 16'h0000, 16'h0000, 1, 1, 16'h7FFF, 0, 0, 1, 0};
        tv[10] = '{1, 0, 16'h0000, 16'h0000, 1, 1, 16'hFFFF, 1, 1, 1, 0};
        tv[11] = '{1, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 0};
        foreach (tv[i]) begin
            en                  = tv[i].en;
            bus.sample_valid_in = tv[i].sv;
            bus.left_sample_in  = tv[i].l;
            bus.right_sample_in = tv[i].r;
            bus.proc_ready_in   = tv[i].rdy;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(bus.proc_valid_out), 32'(tv[i].ev));
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(tv[i].elev));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(tv[i].eovf));
            if (tv[i].ev) begin
                chk($sformatf("vec%0d_word", i), 32'(bus.proc_sample_out), 32'(tv[i].es));
                chk($sformatf("vec%0d_chan", i), 32'(bus.proc_channel_out), 32'(tv[i].ec));
                chk($sformatf("vec%0d_last", i), 32'(bus.proc_last_out), 32'(tv[i].el));
            end
        end
        en = 1'b1;
        bus.sample_valid_in = 1'b0;
        // backpressure: word must hold through a long stall
        bus.proc_ready_in   = 1'b0;
        bus.sample_valid_in = 1'b1;
        bus.left_sample_in  = 16'h1234;
        bus.right_sample_in = 16'hFEDC;
        tick();
        bus.sample_valid_in = 1'b0;
        for (int i = 0; i < 10 && !bus.proc_valid_out; i++) tick();
        chk("bp_valid_rise", 32'(bus.proc_valid_out), 1);
        repeat (20) begin
            tick();
            chk("bp_hold_word", 32'(bus.proc_sample_out), 32'h1234);
            chk("bp_hold_chan", 32'(bus.proc_channel_out), 0);
        end
        bus.proc_ready_in = 1'b1;
        tick();
        chk("bp_right_word", 32'(bus.proc_sample_out), 32'hFEDC);
        chk("bp_right_last", 32'(bus.proc_last_out), 1);
        tick();
        chk("bp_done_valid", 32'(bus.proc_valid_out), 0);
        chk("bp_done_level", 32'(level), 0);
        // overflow: six pairs into a stalled four-deep buffer
        bus.proc_ready_in = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.sample_valid_in = 1'b1;
            bus.left_sample_in  = 16'(i);
            bus.right_sample_in = 16'(i * 256);
            tick();
        end
        bus.sample_valid_in = 1'b0;
        chk("ovf_level", 32'(level), 4);
        chk("ovf_count", 32'(ovf), 2);
        bus.proc_ready_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("ovf_seq_valid", 32'(bus.proc_valid_out), 1);
            chk("ovf_seq_word", 32'(bus.proc_sample_out), (k % 2) ? 32'((k / 2 + 1) * 256) : 32'(k / 2 + 1));
            tick();
        end
        chk("ovf_seq_idle", 32'(bus.proc_valid_out), 0);
        // push coincident with the right-word pop while full
        bus.proc_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.sample_valid_in = 1'b1;
            bus.left_sample_in  = 16'(16'h0100 + i);
            bus.right_sample_in = 16'(16'h0200 + i);
            tick();
        end
        bus.sample_valid_in = 1'b0;
        chk("full_level", 32'(level), 4);
        bus.proc_ready_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b1;
        bus.left_sample_in  = 16'hCAFE;
        bus.right_sample_in = 16'hBEEF;
        tick();
        bus.sample_valid_in = 1'b0;
        bus.proc_ready_in   = 1'b0;
        chk("pushpop_level", 32'(level), 4);
        chk("pushpop_ovf", 32'(ovf), 2);
        en = 1'b0;
        bus.sample_valid_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        en = 1'b1;
        chk("dis_ovf", 32'(ovf), 2);
        chk("dis_level", 32'(level), 4);
        // asynchronous reset while the right word is being offered
        bus.proc_ready_in = 1'b1;
        tick();
        bus.proc_ready_in = 1'b0;
        chk("ar_in_right", 32'(bus.proc_channel_out), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(bus.proc_valid_out), 0);
        chk("ar_level", 32'(level), 0);
        chk("ar_ovf", 32'(ovf), 0);
        chk("ar_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // random traffic with phases of varying backpressure
        for (int p = 0; p < 15; p++) begin
            int rp;
            rp = $urandom_range(0, 4);
            for (int c = 0; c < 200; c++) begin
                en                  = $urandom_range(0, 9) != 0;
                bus.sample_valid_in = $urandom_range(0, 2) == 0;
                bus.left_sample_in  = 16'($urandom);
                bus.right_sample_in = 16'($urandom);
                bus.proc_ready_in   = $urandom_range(0, 3) < rp;
                tick();
            end
        end
        en = 1'b1;
        bus.sample_valid_in = 1'b0;
        bus.proc_ready_in   = 1'b1;
        repeat (12) tick();
        chk("rand_drain_level", 32'(level), 0);
        chk("rand_drain_valid", 32'(bus.proc_valid_out), 0);
        // saturation: 65540 drops behind a permanently stalled engine
        bus.proc_ready_in   = 1'b0;
        bus.sample_valid_in = 1'b1;
        repeat (65544) tick();
        bus.sample_valid_in = 1'b0;
        chk("sat_ovf", 32'(ovf), 32'hFFFF);
        chk("sat_level", 32'(level), 4);
        bus.sample_valid_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        chk("sat_hold", 32'(ovf), 32'hFFFF);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
